rr_chan_mux: RTL
================

RR_CHAN_MUX -- requirements
Module: rr_chan_mux

Interface
REQ-001 Parameter NUM_CH, default 13, number of input channels (2..64).
REQ-002 Parameter WIDTH, default 8, data bits per channel (1..64).
REQ-003 Parameter SELW, default $clog2(NUM_CH), channel-index width; derived, not overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-007 sel  input  SELW  channel index used in fixed mode.
REQ-008 in_data  input  NUM_CH*WIDTH  packed channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-009 in_valid  input  NUM_CH  per-channel valid.
REQ-010 in_ready  output  NUM_CH  per-channel accept strobe.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_ch  output  SELW  index of channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_ch valid.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Output stage SHALL be one register slice; load_en = !out_valid || out_ready.
REQ-016 Fixed mode: grant SHALL be channel sel when sel < NUM_CH and in_valid[sel]=1; otherwise no grant.
REQ-017 sel >= NUM_CH SHALL never grant; no zero-padded or aliased channel is ever output.
REQ-018 Round-robin mode: grant SHALL be the first channel with in_valid=1 searching ptr, ptr+1, ... NUM_CH-1, 0, ... ptr-1.
REQ-019 in_ready[i] SHALL be 1 only when load_en=1, a grant exists and granted index = i; at most one bit set per cycle.
REQ-020 A transfer on channel i occurs when in_valid[i] && in_ready[i]; on that edge out_data <= channel i data, out_ch <= i, out_valid <= 1.
REQ-021 When load_en=1 and no grant exists, out_valid SHALL go 0 on the next edge; out_data/out_ch hold prior values.
REQ-022 When out_valid=1 and out_ready=0, out_data, out_ch, out_valid SHALL hold and all in_ready SHALL be 0.
REQ-023 Simultaneous drain and load (out_valid=1, out_ready=1, grant present) SHALL replace the word in the same edge; sustained throughput 1 word/cycle.
REQ-024 Latency input transfer -> out_valid SHALL be exactly 1 cycle.
REQ-025 ptr (SELW bits) SHALL update only on a round-robin-mode transfer: ptr <= granted+1, wrapping to 0 when granted = NUM_CH-1.
REQ-026 ptr SHALL hold in fixed mode; mode/sel changes take effect on the next load_en cycle, never disturbing a held word.
REQ-027 With NUM_CH not a power of two, ptr SHALL never take values >= NUM_CH.

Reset
REQ-028 While rst_n=0: out_valid=0, out_data=0, out_ch=0, ptr=0, in_ready all 0, asynchronously.
REQ-029 Reset asserted mid-stall SHALL discard the held word; first grant after release is evaluated from ptr=0.

Verification
REQ-030 Fixed mode, NUM_CH=13, sel=12, in_valid[12]=1, in_data ch12=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=12.
REQ-031 Fixed mode, sel=13 or 15, all in_valid=1 -> in_ready=0 every cycle, out_valid stays 0.
REQ-032 RR mode, all 13 in_valid=1, out_ready=1 -> out_ch sequence 0,1,...,12,0,1 on consecutive cycles, one in_ready bit per cycle.
REQ-033 RR mode, in_valid only on ch3 and ch9, ptr=4 -> grants 9 then 3 then 9; ptr wraps correctly.
REQ-034 out_valid=1, out_ready=0 for 5 cycles with inputs changing -> out_data/out_ch constant, in_ready=0; ready release -> next word loads same edge.
REQ-035 rst_n pulsed low asynchronously mid-stall -> outputs zero immediately without clock edge; after release first RR grant searches from ch0.

Source files
------------

// File: rtl/rr_chan_mux.sv
// rr_chan_mux: NUM_CH-input channel multiplexer with a single output register slice.
// Channels are granted either from a fixed index (mode=0) or by a round-robin scan
// that starts at a rotating pointer (mode=1). The selected word is captured into the
// output slice with a valid/ready handshake toward the downstream consumer.
module rr_chan_mux #(
   parameter  int NUM_CH = 13,
   parameter  int WIDTH  = 8,
   localparam int SELW   = $clog2(NUM_CH)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mode,
   input  logic [SELW-1:0]         sel,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   input  logic [NUM_CH-1:0]       in_valid,
   output logic [NUM_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SELW-1:0]         out_ch,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic [WIDTH-1:0]  out_data_r;
   logic [SELW-1:0]   out_ch_r;
   logic              out_valid_r;
   logic [SELW-1:0]   ptr_r;

   logic              load_en_s;
   logic              grant_vld_s;
   logic [SELW-1:0]   grant_idx_s;
   logic [WIDTH-1:0]  grant_data_s;
   logic [SELW-1:0]   ptr_next_s;
   logic [NUM_CH-1:0] in_ready_s;

   // The slice can take a new word when it is empty or its word leaves this cycle.
   assign load_en_s = !out_valid_r || out_ready;

   // Grant selection: fixed index, or a two-pass scan (ptr..NUM_CH-1, then 0..ptr-1).
   // Only real channel indices are ever compared, so sel >= NUM_CH never grants.
   always_comb begin
      grant_vld_s  = 1'b0;
      grant_idx_s  = '0;
      grant_data_s = '0;
      if (mode == 1'b0) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if ((sel == SELW'(i)) && in_valid[i]) begin
               grant_vld_s  = 1'b1;
               grant_idx_s  = SELW'(i);
               grant_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
               grant_vld_s  = grant_vld_s;
            end
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_vld_s && (SELW'(i) >= ptr_r) && in_valid[i]) begin
               grant_vld_s  = 1'b1;
               grant_idx_s  = SELW'(i);
               grant_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
               grant_vld_s  = grant_vld_s;
            end
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_vld_s && (SELW'(i) < ptr_r) && in_valid[i]) begin
               grant_vld_s  = 1'b1;
               grant_idx_s  = SELW'(i);
               grant_data_s = in_data[i*WIDTH +: WIDTH];
            end else begin
               grant_vld_s  = grant_vld_s;
            end
         end
      end
   end

   // Next scan start: one past the granted channel, wrapping at NUM_CH-1 so ptr stays in range.
   always_comb begin
      ptr_next_s = '0;
      if (grant_idx_s == SELW'(NUM_CH - 1)) begin
         ptr_next_s = '0;
      end else begin
         ptr_next_s = grant_idx_s + SELW'(1);
      end
   end

   // One-hot accept strobe to the granted channel; forced low while reset is asserted.
   always_comb begin
      in_ready_s = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         in_ready_s[i] = rst_n && load_en_s && grant_vld_s && (grant_idx_s == SELW'(i));
      end
   end

   // Output slice: load on a transfer, drop valid when free with nothing granted, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_r  <= '0;
         out_ch_r    <= '0;
         out_valid_r <= 1'b0;
      end else if (load_en_s) begin
         if (grant_vld_s) begin
            out_data_r  <= grant_data_s;
            out_ch_r    <= grant_idx_s;
            out_valid_r <= 1'b1;
         end else begin
            out_valid_r <= 1'b0;
         end
      end
   end

   // Round-robin pointer advances only on a transfer made in round-robin mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (load_en_s && grant_vld_s && mode) begin
         ptr_r <= ptr_next_s;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_data  = out_data_r;
   assign out_ch    = out_ch_r;
   assign out_valid = out_valid_r;

endmodule
